alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequences one operation at a time through the shared execute datapath: accepts an op from decode, starts the multi-cycle multiplier or divider when needed, drives the 3-bit select of the registered ALU result mux, and returns the captured 64-bit result with a tag. It sits between decode/issue and the `alu_mux` stage. It owns the mux select and the `*_start` pulses of the multi-cycle units.

## Interface
- `TAG_W`, 4: width of the request/response tag.
- `TIMEOUT`, 64: WAIT-state cycle limit; used only with `ALU_SEQ_TIMEOUT_EN`.

Ports (all synchronous to `clk`; reset is synchronous and active-high):
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  op request valid.
- `req_ready`  out  1  sequencer can accept.
- `req_op`  in  3  op code, equal to the mux select: 0 MUL, 1 DIV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 SLT.
- `req_tag`  in  TAG_W  opaque tag, returned with the result.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_done`  in  1  multiplier result ready; a level or pulse is accepted.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_done`  in  1  divider result ready.
- `alu_sel`  out  3  select driven to the result mux.
- `alu_result`  in  64  registered mux output.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  64  captured result.
- `rsp_tag`  out  TAG_W  tag of the request.
- `rsp_err`  out  1  response produced by a timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, SELECT, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid&&req_ready`, latch op and tag and set `alu_sel`=op.
  - Op 0 or 1 goes to ISSUE. Ops 2–7 go to SELECT.
- ISSUE:
  - Assert `mul_start` (op 0) or `div_start` (op 1) for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - Sample the matching `*_done` from the first cycle after ISSUE. When it is high, go to SELECT.
  - The non-matching `*_done` is ignored.
- SELECT: `alu_sel` is stable. The mux registers the selected input at the end of this cycle. Go to CAPTURE.
- CAPTURE: register `alu_result` into `rsp_data` and the latched tag into `rsp_tag`, then go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data`, `rsp_tag` and `rsp_err` are held stable.
  - On `rsp_valid&&rsp_ready`, go to IDLE.
- `alu_sel` changes only on request acceptance. It holds the last op through IDLE.
- `req_ready`=0 in every state except IDLE, so the request and response handshakes never complete in the same cycle.
- Data width: 32-bit ops rely on the mux zero-extending into bits 63:32. The sequencer passes `alu_result` through unmodified.

## Timing
- Reset values: `req_ready`=0 during reset and 1 from the first cycle after; `mul_start`/`div_start`=0, `alu_sel`=3'b000, `rsp_valid`=0, `rsp_data`=0, `rsp_tag`=0, `rsp_err`=0, `busy`=0. State goes to IDLE.
- Combinational-op latency: accept at edge E0, SELECT in cycle 1, CAPTURE in cycle 2, `rsp_valid` high from cycle 3.
- Multi-cycle op latency: accept at E0, ISSUE in cycle 1, WAIT from cycle 2. If done is first seen in cycle k, SELECT is k+1, CAPTURE is k+2 and `rsp_valid` rises at k+3.
- Peak throughput: one combinational op every 4 cycles when `rsp_ready` is held high.
- `*_done` asserted during ISSUE or IDLE is ignored. Units must not raise done before the cycle after start.
- Reset in any state, including WAIT or RESP, returns to IDLE next cycle and drops `rsp_valid` with no response. The multi-cycle units share the same `reset`.
- Backpressure: RESP holds indefinitely while `rsp_ready`=0. Nothing is lost or overwritten.

## Configuration
- Macro `ALU_SEQ_TIMEOUT_EN`, defined:
  - A counter increments on each WAIT cycle.
  - When it reaches `TIMEOUT` without done, the FSM goes directly to RESP with `rsp_data`=64'hFFFF_FFFF_FFFF_FFFF and `rsp_err`=1.
  - A done arriving in the same cycle as the limit wins, and `rsp_err`=0.
- Macro not defined: WAIT is unbounded, no counter is built, and `rsp_err` is tied to 0. The port is always present.

## Structure
- Shared package `alu_seq_pkg`: op/select encodings (OP_MUL … OP_SLT, 3-bit), the state enum, and the timeout sentinel constant.
- One sub-module, `alu_seq_wdog`: clearable up-counter with a `hit` output at `TIMEOUT`. It is instantiated only under `ALU_SEQ_TIMEOUT_EN`.
- The FSM, output registers and handshake logic live in `alu_op_sequencer`.

## Test plan
- ADD, tag 5, `rsp_ready`=1, mux model returns 0x1234 → `alu_sel`=2; `rsp_valid` rises 3 cycles after accept with `rsp_data`=0x1234, `rsp_tag`=5, `rsp_err`=0.
- MUL, `mul_done` 6 cycles after `mul_start` → `mul_start` is a single-cycle pulse and `div_start` stays 0; response `rsp_valid` 3 cycles after done with the 64-bit product intact.
- `rsp_ready`=0 for 10 cycles, then a new `req_valid` → `rsp_valid` and `rsp_data` held stable, `req_ready`=0 throughout, the new request is accepted only the cycle after the response handshake.
- `reset` asserted during WAIT of a DIV → next cycle IDLE, `busy`=0, `rsp_valid`=0; a subsequent XOR completes normally.
- With `ALU_SEQ_TIMEOUT_EN` and `TIMEOUT`=8, DIV with `div_done` never asserted → response after 8 WAIT cycles with `rsp_err`=1 and `rsp_data` all ones. Without the macro → still `busy` after 100 cycles.
- SLT directly after MUL, with `div_done` toggled during the MUL → stray done ignored; `alu_sel` sequence 0 then 7, and both responses are correct and in order.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU op sequencer: op/mux-select codes, FSM states,
// and the data word returned when a multi-cycle unit times out.
package alu_seq_pkg;

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_DIV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SELECT,
    S_CAPTURE,
    S_RESP
  } seq_state_e;

  localparam logic [63:0] TIMEOUT_DATA = '1;

  function automatic logic is_multi_cycle(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_wdog.sv
// Clearable WAIT-cycle counter; hit_o flags the cycle in which the count of
// enabled cycles reaches TIMEOUT. Only instantiated under ALU_SEQ_TIMEOUT_EN.
module alu_seq_wdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  // hit_o counts the current cycle, so the limit lands on the TIMEOUT-th WAIT cycle
  assign hit_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !hit_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// One-op-at-a-time sequencer for the shared execute datapath; owns the result
// mux select and the multiplier/divider start pulses. Macro: ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mul_start,
  input  logic             mul_done,
  output logic             div_start,
  input  logic             div_done,
  output logic [2:0]       alu_sel,
  input  logic [63:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic             unit_done;
  logic             to_fire;

  assign unit_done = (sel_q == OP_MUL) ? mul_done : div_done;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic wd_hit;
  logic err_q;

  alu_seq_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk  (clk),
    .reset(reset),
    .clr_i(state_q == S_ISSUE),
    .en_i (state_q == S_WAIT),
    .hit_o(wd_hit)
  );

  // a done coinciding with the limit takes the normal path
  assign to_fire = wd_hit && !unit_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == S_WAIT && to_fire) begin
      err_q <= 1'b1;
    end else if (state_q == S_CAPTURE) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign to_fire = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign mul_start = (state_q == S_ISSUE) && (sel_q == OP_MUL);
  assign div_start = (state_q == S_ISSUE) && (sel_q == OP_DIV);
  assign alu_sel   = sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tag_d      = tag_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          sel_d   = req_op;
          tag_d   = req_tag;
          state_d = is_multi_cycle(req_op) ? S_ISSUE : S_SELECT;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (unit_done) begin
          state_d = S_SELECT;
        end else if (to_fire) begin
          rsp_data_d = TIMEOUT_DATA;
          rsp_tag_d  = tag_q;
          state_d    = S_RESP;
        end
      end
      S_SELECT: state_d = S_CAPTURE;
      S_CAPTURE: begin
        rsp_data_d = alu_result;
        rsp_tag_d  = tag_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      tag_q      <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tag_q      <= tag_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against a cycle-count
// reference model; timeout scenario depends on ALU_SEQ_TIMEOUT_EN.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned TMO   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic             mul_start;
  logic             mul_done;
  logic             div_start;
  logic             div_done;
  logic [2:0]       alu_sel;
  logic [63:0]      alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] tbl [8];
  logic [2:0]  last_op;

  alu_op_sequencer #(
    .TAG_W  (TAG_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_tag   (req_tag),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .div_start (div_start),
    .div_done  (div_done),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // registered result mux: one value per select code
  always @(posedge clk) alu_result <= tbl[alu_sel];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // dly: cycles from start to done (0 = done never comes); hold: cycles of
  // rsp_ready=0 after rsp_valid rises; stray: toggle the unrelated done line
  task automatic run_op(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                        input int unsigned dly, input int unsigned hold, input bit stray);
    logic [63:0] exp_data;
    int unsigned exp_lat, cyc, rv_cyc;
    bit fin, tmo, multi;
    multi = (op == OP_MUL) || (op == OP_DIV);
    tmo   = multi && (dly == 0);
    for (int i = 0; i < 8; i++) tbl[i] = {$urandom, $urandom};
    exp_data = tmo ? 64'hFFFF_FFFF_FFFF_FFFF : tbl[op];
    exp_lat  = !multi ? 3 : (tmo ? TMO + 2 : dly + 4);
    req_valid = 1'b1;
    req_op    = op;
    req_tag   = tag;
    @(negedge clk);
    check("idle_sel_hold", alu_sel, last_op);
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_tag   = TAG_W'($urandom);
    last_op   = op;
    cyc = 1; rv_cyc = 0; fin = 0;
    while (!fin && cyc < 400) begin
      mul_done = (op == OP_MUL && dly != 0 && cyc == 1 + dly)
               || (stray && op != OP_MUL && $urandom_range(1) == 1)
               || (stray && op == OP_MUL && cyc == 1);
      div_done = (op == OP_DIV && dly != 0 && cyc == 1 + dly)
               || (stray && op != OP_DIV && $urandom_range(1) == 1)
               || (stray && op == OP_DIV && cyc == 1);
      rsp_ready = (hold == 0) || (rv_cyc != 0 && cyc >= rv_cyc + hold);
      if (rv_cyc != 0 && hold != 0) begin
        req_valid = 1'b1;
        req_op    = 3'($urandom);
      end
      @(negedge clk);
      check("mul_start", mul_start, op == OP_MUL && cyc == 1);
      check("div_start", div_start, op == OP_DIV && cyc == 1);
      check("alu_sel", alu_sel, op);
      check("busy", busy, 1);
      check("req_ready_busy", req_ready, 0);
      check("rsp_valid", rsp_valid, cyc >= exp_lat);
      if (rsp_valid) begin
        if (rv_cyc == 0) rv_cyc = cyc;
        check("rsp_data", rsp_data, exp_data);
        check("rsp_tag", rsp_tag, tag);
        check("rsp_err", rsp_err, tmo);
        fin = rsp_ready;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) check("rsp_handshake_bound", 0, 1);
    mul_done  = 1'b0;
    div_done  = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic reset_in_wait(input int unsigned wait_cyc);
    req_valid = 1'b1;
    req_op    = OP_DIV;
    req_tag   = TAG_W'($urandom);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (wait_cyc) begin
      @(negedge clk);
      check("rst_busy_wait", busy, 1);
      check("rst_no_rsp", rsp_valid, 0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_req_ready", req_ready, 1);
    last_op = OP_MUL;
    @(posedge clk); #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_tag   = '0;
    mul_done  = 1'b0;
    div_done  = 1'b0;
    rsp_ready = 1'b0;
    last_op   = OP_MUL;
    for (int i = 0; i < 8; i++) tbl[i] = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_mul_start", mul_start, 0);
    check("reset_div_start", div_start, 0);
    check("reset_alu_sel", alu_sel, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_tag", rsp_tag, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(OP_ADD, 4'd5, 0, 0, 1'b0);
    run_op(OP_MUL, 4'd3, 6, 0, 1'b0);
    run_op(OP_SUB, 4'd9, 0, 10, 1'b0);
    run_op(OP_AND, 4'd1, 0, 0, 1'b0);
`ifdef ALU_SEQ_TIMEOUT_EN
    reset_in_wait(4);
    run_op(OP_XOR, 4'd7, 0, 0, 1'b0);
    run_op(OP_DIV, 4'd12, 0, 0, 1'b0);
    run_op(OP_DIV, 4'd13, TMO, 0, 1'b0);
`else
    reset_in_wait(100);
    run_op(OP_XOR, 4'd7, 0, 0, 1'b0);
`endif
    run_op(OP_MUL, 4'd10, 5, 0, 1'b1);
    run_op(OP_SLT, 4'd11, 0, 0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(7));
      run_op(op, TAG_W'($urandom), 1 + $urandom_range(6), $urandom_range(3), 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
